// File: rtl/stage3_pkg.sv
// Shared definitions for the masked S-box output stage: tower-field GF16 arithmetic
// and the linear maps back to the AES polynomial basis.
package stage3_pkg;

   localparam int unsigned GfW   = 4;
   localparam int unsigned ByteW = 8;

   localparam logic [ByteW-1:0] SboxConst = 8'h63;

   // Tower basis: GF16 = GF(2)[w]/(w^4+w+1); a byte is hi*Y^16 + lo*Y with Y^2+Y+(w^3+1)=0.
   // Columns hold the AES-basis images of bits 0..7 of {hi, lo}.
   localparam logic [ByteW-1:0][ByteW-1:0] MinvCols = {
      8'hD8, 8'h0F, 8'h4B, 8'h12, 8'hD4, 8'h53, 8'hAA, 8'h13
   };

   // AES affine matrix, one column per input bit.
   localparam logic [ByteW-1:0][ByteW-1:0] AffCols = {
      8'h8F, 8'hC7, 8'hE3, 8'hF1, 8'hF8, 8'h7C, 8'h3E, 8'h1F
   };

   typedef struct packed {
      logic [GfW-1:0] t00;
      logic [GfW-1:0] t01;
      logic [GfW-1:0] t10;
      logic [GfW-1:0] t11;
   } dom_terms_t;

   function automatic logic [GfW-1:0] gf16_mul(input logic [GfW-1:0] a,
                                               input logic [GfW-1:0] b);
      logic [GfW-1:0] acc;
      logic [GfW-1:0] sh;
      acc = '0;
      sh  = a;
      for (int unsigned i = 0; i < GfW; i++) begin
         if (b[i]) begin
            acc = acc ^ sh;
         end
         sh = {sh[GfW-2:0], 1'b0} ^ (sh[GfW-1] ? 4'h3 : 4'h0);
      end
      return acc;
   endfunction

   function automatic logic [ByteW-1:0] lin_map(input logic [ByteW-1:0][ByteW-1:0] cols,
                                                input logic [ByteW-1:0]             x);
      logic [ByteW-1:0] acc;
      acc = '0;
      for (int unsigned j = 0; j < ByteW; j++) begin
         if (x[j]) begin
            acc = acc ^ cols[j];
         end
      end
      return acc;
   endfunction

   // Affine-of-basis-change, applied identically to each share.
   function automatic logic [ByteW-1:0] share_out_map(input logic [GfW-1:0] hi,
                                                      input logic [GfW-1:0] lo);
      return lin_map(AffCols, lin_map(MinvCols, {hi, lo}));
   endfunction

endpackage

// File: rtl/gf16_mul_dom.sv
// First-order DOM GF16 multiplier: cross-domain terms are refreshed with r and registered
// before compression, so shares never recombine combinationally.
module gf16_mul_dom
   import stage3_pkg::*;
(
   input  logic           CLK,
   input  logic           RST_N,
   input  logic [GfW-1:0] a0,
   input  logic [GfW-1:0] a1,
   input  logic [GfW-1:0] b0,
   input  logic [GfW-1:0] b1,
   input  logic [GfW-1:0] r,
   output logic [GfW-1:0] c0,
   output logic [GfW-1:0] c1
);

   dom_terms_t terms_d;
   dom_terms_t terms_q;

   always_comb begin
      terms_d     = '0;
      terms_d.t00 = gf16_mul(a0, b0);
      terms_d.t01 = gf16_mul(a0, b1) ^ r;
      terms_d.t10 = gf16_mul(a1, b0) ^ r;
      terms_d.t11 = gf16_mul(a1, b1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         terms_q <= '0;
      end else begin
         terms_q <= terms_d;
      end
   end

   always_comb begin
      c0 = terms_q.t00 ^ terms_q.t01;
      c1 = terms_q.t11 ^ terms_q.t10;
   end

endmodule

// File: rtl/stage3_mul_out.sv
// Final masked S-box stage: two DOM multipliers, sharewise linear output map and an
// output register; a two-deep valid pipeline tracks the always-loading data path.
module stage3_mul_out
   import stage3_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             valid_in,
   input  logic [GfW-1:0]   inv0,
   input  logic [GfW-1:0]   inv1,
   input  logic [GfW-1:0]   h0,
   input  logic [GfW-1:0]   h1,
   input  logic [GfW-1:0]   l0,
   input  logic [GfW-1:0]   l1,
   input  logic [GfW-1:0]   rh,
   input  logic [GfW-1:0]   rl,
   output logic [ByteW-1:0] out0,
   output logic [ByteW-1:0] out1,
   output logic             valid_out
);

   logic [GfW-1:0]   hi0;
   logic [GfW-1:0]   hi1;
   logic [GfW-1:0]   lo0;
   logic [GfW-1:0]   lo1;
   logic [1:0]       valid_d;
   logic [1:0]       valid_q;
   logic [ByteW-1:0] out0_d;
   logic [ByteW-1:0] out0_q;
   logic [ByteW-1:0] out1_d;
   logic [ByteW-1:0] out1_q;

   // Normal-basis inverse: the high half pairs with l, the low half with h.
   gf16_mul_dom u_mul_hi (
      .CLK   (CLK),
      .RST_N (RST_N),
      .a0    (inv0),
      .a1    (inv1),
      .b0    (l0),
      .b1    (l1),
      .r     (rh),
      .c0    (hi0),
      .c1    (hi1)
   );

   gf16_mul_dom u_mul_lo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .a0    (inv0),
      .a1    (inv1),
      .b0    (h0),
      .b1    (h1),
      .r     (rl),
      .c0    (lo0),
      .c1    (lo1)
   );

   always_comb begin
      valid_d = {valid_q[0], valid_in};
      // The affine constant is folded into share 0 only.
      out0_d  = share_out_map(hi0, lo0) ^ SboxConst;
      out1_d  = share_out_map(hi1, lo1);
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         valid_q <= '0;
         out0_q  <= '0;
         out1_q  <= '0;
      end else begin
         valid_q <= valid_d;
         out0_q  <= out0_d;
         out1_q  <= out1_d;
      end
   end

   assign out0      = out0_q;
   assign out1      = out1_q;
   assign valid_out = valid_q[1];

endmodule

// File: tb/tb_stage3_mul_out.sv
// Randomized bench for stage3_mul_out: inputs are derived from plain GF(2^8) arithmetic and
// outputs are compared against the AES S-box computed directly in that field.
module tb_stage3_mul_out;

   localparam int ModeRand = 0;
   localparam int ModeZero = 1;
   localparam int ModeNz   = 2;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       valid_in;
   logic [3:0] inv0, inv1, h0, h1, l0, l1, rh, rl;
   logic [7:0] out0, out1;
   logic       valid_out;

   always #5 CLK = ~CLK;

   stage3_mul_out dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .valid_in  (valid_in),
      .inv0      (inv0),
      .inv1      (inv1),
      .h0        (h0),
      .h1        (h1),
      .l0        (l0),
      .l1        (l1),
      .rh        (rh),
      .rl        (rl),
      .out0      (out0),
      .out1      (out1),
      .valid_out (valid_out)
   );

   typedef struct packed {
      logic       v;
      logic       iso;
      logic [7:0] x;
      logic [7:0] s;
   } exp_t;

   exp_t       pipe[$];
   logic [7:0] to_tower [256];
   int         n_checks = 0;
   int         n_pass   = 0;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] gpow(input logic [7:0] a, input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < n; i++) r = gmul(r, a);
      return r;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      return gpow(a, 254);
   endfunction

   function automatic logic [7:0] aff(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return aff(ginv(x));
   endfunction

   // GF16 subfield element with coordinates n over powers of w = 0xE1 (w^4 = w + 1).
   function automatic logic [7:0] sub_eval(input logic [3:0] n);
      logic [7:0] acc;
      logic [7:0] pw;
      acc = 8'h00;
      pw  = 8'h01;
      for (int i = 0; i < 4; i++) begin
         if (n[i]) acc = acc ^ pw;
         pw = gmul(pw, 8'hE1);
      end
      return acc;
   endfunction

   function automatic logic [3:0] sub_coord(input logic [7:0] v);
      logic [3:0] r;
      r = 4'h0;
      for (int n = 0; n < 16; n++) begin
         if (sub_eval(4'(n)) == v) r = 4'(n);
      end
      return r;
   endfunction

   task automatic drive_in(input logic v, input logic [7:0] x, input logic rst_n,
                           input int mode);
      logic [7:0] tw;
      logic [3:0] iv, mi, mh, ml;
      tw = to_tower[x];
      // Inverse of the norm x^17, which lives in GF16.
      iv = sub_coord(ginv(gpow(x, 17)));
      if (mode == ModeZero) begin
         mi = 4'h0; mh = 4'h0; ml = 4'h0;
         rh = 4'h0; rl = 4'h0;
      end else if (mode == ModeNz) begin
         mi = 4'($urandom_range(1, 15));
         mh = 4'($urandom_range(1, 15));
         ml = 4'($urandom_range(1, 15));
         rh = 4'($urandom_range(1, 15));
         rl = 4'($urandom_range(1, 15));
      end else begin
         mi = 4'($urandom()); mh = 4'($urandom()); ml = 4'($urandom());
         rh = 4'($urandom()); rl = 4'($urandom());
      end
      valid_in = v;
      RST_N    = rst_n;
      inv0     = iv ^ mi;
      inv1     = mi;
      h0       = tw[7:4] ^ mh;
      h1       = mh;
      l0       = tw[3:0] ^ ml;
      l1       = ml;
   endtask

   // One clock: offer an input, then check what the model says should emerge now.
   task automatic step(input logic v, input logic [7:0] x, input logic rst_n, input int mode);
      exp_t e;
      drive_in(v, x, rst_n, mode);
      @(posedge CLK);
      #1;
      if (!rst_n) begin
         pipe.delete();
         pipe.push_back('0);
         check_eq("rst_valid_out", {7'b0, valid_out}, 8'h00);
         check_eq("rst_out0", out0, 8'h00);
         check_eq("rst_out1", out1, 8'h00);
      end else begin
         e = (pipe.size() > 0) ? pipe.pop_front() : '0;
         pipe.push_back('{v: v, iso: (mode == ModeZero), x: x, s: sbox(x)});
         check_eq("valid_out", {7'b0, valid_out}, {7'b0, e.v});
         if (e.v) check_eq($sformatf("sbox_%02h", e.x), out0 ^ out1, e.s);
         if (e.v && e.iso) check_eq($sformatf("iso_out1_%02h", e.x), out1, 8'h00);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] xa;
      logic [7:0] exp_new;
      logic [4:0] pat;

      for (int t = 0; t < 256; t++) begin
         b = gmul(sub_eval(4'(t >> 4)), 8'h12) ^ gmul(sub_eval(4'(t)), 8'h13);
         to_tower[b] = 8'(t);
      end

      // Reset coinciding with a valid byte: the byte must vanish.
      step(1'b1, 8'h5A, 1'b0, ModeRand);
      step(1'b0, 8'h00, 1'b1, ModeRand);

      // Golden: byte 0x00 with all masks and randomness zero.
      step(1'b1, 8'h00, 1'b1, ModeZero);
      step(1'b0, 8'h00, 1'b1, ModeRand);
      step(1'b0, 8'h00, 1'b1, ModeRand);

      for (int i = 0; i < 1000; i++) step(1'b1, 8'h53, 1'b1, ModeNz);

      for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b1, ModeRand);

      pat = 5'b01101;
      for (int i = 0; i < 5; i++) step(pat[i], 8'($urandom()), 1'b1, ModeRand);
      step(1'b0, 8'h00, 1'b1, ModeRand);
      step(1'b0, 8'h00, 1'b1, ModeRand);

      // Mid-stream reset with bytes in flight.
      step(1'b1, 8'($urandom()), 1'b1, ModeRand);
      step(1'b1, 8'($urandom()), 1'b1, ModeRand);
      step(1'b1, 8'($urandom()), 1'b0, ModeRand);
      step(1'b1, 8'($urandom()), 1'b1, ModeRand);
      step(1'b0, 8'h00, 1'b1, ModeRand);
      step(1'b0, 8'h00, 1'b1, ModeRand);

      // Share isolation: domain 1 all zero, then toggle inv0 alone.
      xa = 8'hA7;
      drive_in(1'b1, xa, 1'b1, ModeZero);
      repeat (2) @(posedge CLK);
      #1;
      check_eq("iso_hold_out0", out0, sbox(xa));
      check_eq("iso_hold_out1", out1, 8'h00);
      inv0    = inv0 ^ 4'h6;
      exp_new = aff(gmul(sub_eval(inv0), gpow(xa, 16)));
      @(posedge CLK);
      #1;
      check_eq("iso_reg1_out0", out0, sbox(xa));
      check_eq("iso_reg1_out1", out1, 8'h00);
      @(posedge CLK);
      #1;
      check_eq("iso_reg2_out0", out0, exp_new);
      check_eq("iso_reg2_out1", out1, 8'h00);
      step(1'b0, 8'h00, 1'b0, ModeRand);

      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom()), ($urandom_range(0, 39) != 0),
              ($urandom_range(0, 3) == 0) ? ModeZero : ModeRand);
      end
      step(1'b0, 8'h00, 1'b1, ModeRand);
      step(1'b0, 8'h00, 1'b1, ModeRand);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stage3_mul_out.md
STAGE3_MUL_OUT -- requirements
Module: stage3_mul_out

Interface
REQ-001 SHALL expose: CLK  in  1  single clock; all state updates on the rising edge.
REQ-002 SHALL expose: RST_N  in  1  reset, synchronous, active-low.
REQ-003 SHALL expose: valid_in  in  1  input shares below are valid this cycle.
REQ-004 SHALL expose: inv0, inv1  in  4 each  Boolean shares of the GF16 inverse produced by the upstream inversion stage.
REQ-005 SHALL expose: h0, h1, l0, l1  in  4 each  registered high and low GF16 halves, time-aligned with inv0/inv1.
REQ-006 SHALL expose: rh, rl  in  4 each  fresh randomness for the high-half and low-half multipliers, consumed every cycle.
REQ-007 SHALL expose: out0, out1  out  8 each  Boolean shares of the S-box output byte.
REQ-008 SHALL expose: valid_out  out  1  out0/out1 are valid this cycle.

Function
REQ-009 Unmasked operation: SHALL compute hi = inv*l and lo = inv*h in GF16, then S = A(M^-1(hi||lo)) xor 0x63.
- M^-1: inverse tower-field basis change.
- A: AES affine matrix.
- Shares are combined so that out0 xor out1 = S.
REQ-010 Each GF16 multiplication SHALL be a first-order DOM multiplier.
- Register 1 holds four 4-bit terms: a0*b0, a0*b1 xor r, a1*b0 xor r, a1*b1, where r is rh or rl.
- Compression: share0 = t00 xor t01, share1 = t11 xor t10.
- Compression is combinational after register 1.
REQ-011 M^-1, A and the 0x63 constant SHALL be applied sharewise and linearly. The constant is added to share 0 only.
REQ-012 Register 2 SHALL capture out0/out1. No combinational path SHALL exist from any input to any output.
REQ-013 Latency SHALL be exactly 2 cycles: valid_in high at edge k gives valid_out high after edge k+2.
REQ-014 Throughput SHALL be one byte per cycle. There is no backpressure, and back-to-back valid_in SHALL be accepted every cycle.
REQ-015 A 2-stage valid shift register SHALL track data.
- Data registers SHALL load every cycle regardless of valid_in, so that the mask-refresh timing is constant.
- valid_out qualifies the outputs.
REQ-016 When valid_out is low, out0/out1 content is don't-care for consumers. The bench SHALL NOT check it, except after reset (REQ-018).
REQ-017 Randomness SHALL be sampled in the same cycle as inv/h/l (register-1 cycle) and SHALL NOT be reused across multipliers.

Reset
REQ-018 While RST_N is low at an edge, both valid stages, all register-1 terms and out0/out1 SHALL clear to 0.
REQ-019 Reset asserted mid-stream SHALL drop all in-flight bytes.
- valid_out SHALL be 0 on the cycle after reset is sampled.
- The first post-reset valid_out SHALL appear 2 cycles after the first valid_in accepted with RST_N high.
REQ-020 Reset and valid_in in the same cycle: reset SHALL win and the input SHALL be discarded.

Structure
REQ-021 Shared package stage3_pkg SHALL hold:
- the GF16 multiplication function,
- the M^-1 and affine matrices,
- the 0x63 constant.
The tower basis and GF16 multiplication SHALL be identical to those used by the upstream isomorphism and inversion stages.
REQ-022 One sub-module, gf16_mul_dom, SHALL implement REQ-010 and be instantiated twice. It takes CLK and RST_N, with 4-bit shares a0/a1/b0/b1, r, and outputs c0/c1.
REQ-023 Remaining logic (linear output map, valid pipeline, register 2) SHALL live in stage3_mul_out.

Verification
REQ-024 Golden model:
- full masked S-box chain, input byte 0x00, all masks and randomness 0;
- drive the resulting inv/h/l shares;
- required: two cycles later valid_out=1 and out0 xor out1 = 0x63.
REQ-025 Input 0x53 with random nonzero masks and random rh/rl: required out0 xor out1 = 0xED. Repeat with 1000 random masks and randomness; the result SHALL be invariant.
REQ-026 All 256 input bytes driven back-to-back with valid_in held high: required 256 consecutive valid_out pulses in order, each matching the AES S-box.
REQ-027 valid_in pattern 1,0,1,1,0: required valid_out pattern 1,0,1,1,0 delayed by exactly 2 cycles.
REQ-028 RST_N pulled low for 1 cycle while two bytes are in flight:
- required: valid_out=0 and out0=out1=0x00 the following cycle;
- neither dropped byte emerges;
- the next accepted byte emerges 2 cycles after acceptance.
REQ-029 Share-isolation check: with inv1=h1=l1=0 and rh=rl=0, out1 SHALL depend only on cross-domain terms. Toggling inv0 alone SHALL change out0 only via the registered path, one cycle after register 1.
